// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - HI/LO bus width and field positions of {hi_we, lo_we, hi, lo}
//   - iteration count of the sequential multiply/divide engines
//   - FSM state encoding (2 bits)
//   - quotient returned on divide by zero
//   - mag32(): two's-complement magnitude helper
package hilo_muldiv_pkg;

  localparam int HILO_BUS_WD = 66;
  localparam int HI_WE       = 65;
  localparam int LO_WE       = 64;
  localparam int HI_MSB      = 63;
  localparam int HI_LSB      = 32;
  localparam int LO_MSB      = 31;
  localparam int LO_LSB      = 0;

  // Fixed to the 32-bit operand width; not intended to be overridden.
  localparam int ITER = 32;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Magnitude of v when it is interpreted as signed, else v unchanged.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// div_iter: unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   abort          drop an operation in progress
//   start          capture dividend/divisor and begin (ignored while busy)
//   dividend       32-bit unsigned dividend
//   divisor        32-bit unsigned divisor
//   busy           high while iterating
//   done           high during the final iteration cycle
//   quotient       32-bit quotient (valid after done)
//   remainder      32-bit remainder (valid after done)
module div_iter
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [32:0] prem;
  logic [31:0] quot;
  logic [31:0] dvsr;
  logic [4:0]  cnt;
  logic [33:0] trial;
  logic        fits;

  // The dividend is shifted out of quot MSB-first into the partial
  // remainder; quotient bits are shifted in at the bottom of quot.
  assign trial = {prem, quot[31]} - {2'b00, dvsr};
  assign fits  = ~trial[33];

  assign done      = busy && (cnt == 5'(ITER - 1));
  assign quotient  = quot;
  assign remainder = prem[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      prem <= '0;
      quot <= '0;
      dvsr <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= '0;
      prem <= '0;
      quot <= dividend;
      dvsr <= divisor;
    end else if (busy) begin
      prem <= fits ? trial[32:0] : {prem[31:0], quot[31]};
      quot <= {quot[30:0], fits};
      cnt  <= cnt + 5'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: execute-stage HI/LO producer for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          abort any operation, return to IDLE
//   ex_hold        downstream stall; holds a finished result on the bus
//   op_*           one-hot-ish decoded op (priority div>divu>mult>multu>mthi>mtlo)
//   src1, src2     rs / rt operands
//   hilo_bus       {hi_we, lo_we, hi[31:0], lo[31:0]}
//   stallreq       hold IF/ID/EX while a multi-cycle op is in flight
// Build option: define HILO_FAST_MUL_EN for a single-cycle multiplier
// (IDLE -> DONE directly for MULT/MULTU). Division is always iterative.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   ex_hold,
  input  logic                   op_mult,
  input  logic                   op_multu,
  input  logic                   op_div,
  input  logic                   op_divu,
  input  logic                   op_mthi,
  input  logic                   op_mtlo,
  input  logic [31:0]            src1,
  input  logic [31:0]            src2,
  output logic [HILO_BUS_WD-1:0] hilo_bus,
  output logic                   stallreq
);

  state_e      state;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [31:0] mcand;
  logic [31:0] src1_raw;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;

  logic        sel_div, sel_mul, sel_mthi, sel_mtlo, sel_signed;
  logic [31:0] mag1, mag2;
  logic        div_start, div_busy, div_done;
  logic [31:0] div_quot, div_rem;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    sel_div    = op_div | op_divu;
    sel_mul    = ~sel_div & (op_mult | op_multu);
    sel_mthi   = ~sel_div & ~sel_mul & op_mthi;
    sel_mtlo   = ~sel_div & ~sel_mul & ~op_mthi & op_mtlo;
    sel_signed = sel_div ? op_div : op_mult;
  end

  assign mag1      = mag32(src1, sel_signed);
  assign mag2      = mag32(src2, sel_signed);
  assign div_start = (state == IDLE) && sel_div && !flush;

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .abort     (flush),
    .start     (div_start),
    .dividend  (mag1),
    .divisor   (mag2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  // Shift-add step: multiplier sits in acc[31:0] and is consumed LSB-first
  // while the partial product grows in the upper half.
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      src1_raw <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (sel_div) begin
            is_div   <= 1'b1;
            neg_res  <= op_div & (src1[31] ^ src2[31]);
            neg_rem  <= op_div & src1[31];
            div_zero <= (src2 == 32'd0);
            src1_raw <= src1;
            state    <= DIV_RUN;
          end else if (sel_mul) begin
            is_div   <= 1'b0;
            neg_res  <= op_mult & (src1[31] ^ src2[31]);
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
`ifdef HILO_FAST_MUL_EN
            acc      <= {32'd0, mag1} * {32'd0, mag2};
            state    <= DONE;
`else
            acc      <= {32'd0, mag2};
            mcand    <= mag1;
            state    <= MUL_RUN;
`endif
          end
        end
        MUL_RUN: begin
          acc   <= {mul_sum, acc[31:1]};
          count <= count + 5'd1;
          if (count == 5'(ITER - 1)) state <= DONE;
        end
        DIV_RUN: begin
          count <= count + 5'd1;
          if (div_done) state <= DONE;
        end
        DONE: begin
          if (!ex_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sign correction is applied to the stored magnitudes when presenting.
  always_comb begin
    prod_fix = neg_res ? (64'd0 - acc) : acc;
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = src1_raw;
        res_lo = DIV_ZERO_QUOT;
      end else begin
        res_hi = neg_rem ? (32'd0 - div_rem)  : div_rem;
        res_lo = neg_res ? (32'd0 - div_quot) : div_quot;
      end
    end
  end

  always_comb begin
    hilo_bus = '0;
    stallreq = 1'b0;
    if (!rst && !flush) begin
      case (state)
        IDLE: begin
          if (sel_div || sel_mul) begin
            stallreq = 1'b1;
          end else if (sel_mthi) begin
            hilo_bus[HI_WE]          = 1'b1;
            hilo_bus[HI_MSB:HI_LSB]  = src1;
          end else if (sel_mtlo) begin
            hilo_bus[LO_WE]          = 1'b1;
            hilo_bus[LO_MSB:LO_LSB]  = src1;
          end
        end
        MUL_RUN: stallreq = 1'b1;
        DIV_RUN: stallreq = div_busy;
        DONE: begin
          hilo_bus[HI_WE]         = 1'b1;
          hilo_bus[LO_WE]         = 1'b1;
          hilo_bus[HI_MSB:HI_LSB] = res_hi;
          hilo_bus[LO_MSB:LO_LSB] = res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
